fp_mantissa_normalizer: RTL and testbench
=========================================

Name: fp_mantissa_normalizer

Overview:
- Downstream stage of the floating-point BigALU datapath.
- Consumes the raw 25-bit mantissa result (carry bit, hidden bit and 23 fraction bits) from a sum or multiply, plus its sign and biased exponent.
- Normalizes iteratively, one shift per clock: right shift on carry-out, left shifts while the hidden bit is 0. Adjusts the exponent and flags zero, overflow and underflow.
- Handshake is start/busy/done, so the FP control unit can chain it after the ALU signals completion (endMultiplication, or end of sum).

Parameters:
- MANT_W, 23, fraction width; the internal mantissa register is MANT_W+2 bits.
- EXP_W, 8, biased exponent width; all-ones means infinity.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request; captures the inputs when the block is idle.
- sign_in  input  1  sign of the raw result.
- exponent_in  input  EXP_W  biased exponent of the raw result.
- mantissa_in  input  MANT_W+2  bit 24 = carry, bit 23 = hidden bit, bits 22:0 = fraction.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the outputs are valid.
- sign_out  output  1  registered sign.
- exponent_out  output  EXP_W  normalized biased exponent.
- fraction_out  output  MANT_W  normalized fraction, hidden bit dropped.
- zero  output  1  result is exactly zero.
- overflow  output  1  result saturated to infinity.
- underflow  output  1  result flushed to zero because the exponent went too small.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (reset_n).
- Reset state: IDLE. busy, done, sign_out, zero, overflow and underflow are 0. exponent_out and fraction_out are 0. The internal mantissa and exponent registers are 0.
- States are IDLE, CHECK and DONE.
- IDLE:
  - start=1 captures sign_in, exponent_in and mantissa_in, clears all flags, and moves to CHECK.
  - start=0 holds the previous outputs.
- CHECK evaluates the first matching rule, one rule per cycle:
  1. mantissa==0: zero=1, exponent 0, fraction 0, go to DONE.
  2. exponent==all-ones: overflow=1, exponent all-ones, fraction 0, go to DONE.
  3. exponent==0 (mantissa nonzero): underflow=1, exponent 0, fraction 0, go to DONE.
  4. bit24==1:
     - If exponent==all-ones-1: overflow=1, exponent all-ones, fraction 0, go to DONE.
     - Else: shift mantissa right 1 (LSB truncated), exponent+1, stay in CHECK.
  5. bit23==0:
     - If exponent==1: underflow=1, exponent 0, fraction 0, go to DONE.
     - Else: shift mantissa left 1 (0 enters the LSB), exponent-1, stay in CHECK.
  6. Otherwise (normalized): fraction_out = mantissa[22:0], exponent_out = exponent, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE. Outputs hold until the next accepted start.
- Sign: sign_out = captured sign in every case, including zero, overflow and underflow.
- busy: 1 in CHECK and DONE-entry cycles, i.e. from the cycle after the start edge up to, but not including, the done cycle.
- Latency: done is asserted (2 + number of shifts) rising edges after the edge that samples start.
  - Normalized input: 2 cycles.
  - Carry-out: 3 cycles.
  - Maximum left shift (23 shifts): 25 cycles.
- Rounding: truncation only. No sticky or guard bits.
- start while busy (CHECK or DONE): ignored, no effect on the operation in flight.
- Simultaneous start and done cycle: start is ignored. It is accepted only in IDLE.
- reset_n low at any time: immediate return to the reset state, in-flight result discarded, no done pulse.
- Exponent arithmetic is unsigned EXP_W bits. The boundary checks in rules 4 and 5 guarantee no wrap-around.

Test Plan:
- mantissa_in=25'h0800000, exponent_in=127, sign_in=0, start pulse -> done 2 cycles later; exponent_out=127, fraction_out=0, all flags 0.
- mantissa_in=25'h1800000 (carry, sum 3.0), exponent_in=127 -> done after 3 cycles; exponent_out=128, fraction_out=23'h400000.
- mantissa_in=25'h0000001, exponent_in=127, sign_in=1 -> busy for 23 shift cycles, done at cycle 25; exponent_out=104, fraction_out=0, sign_out=1.
- Boundaries, one case each:
  - mantissa_in=0, exponent_in=90 -> zero=1, exponent_out=0, done at cycle 2.
  - mantissa_in=25'h1000000, exponent_in=254 -> overflow=1, exponent_out=255, fraction_out=0.
  - mantissa_in=25'h0000010, exponent_in=5 -> underflow=1, exponent_out=0, fraction_out=0.
- start pulsed again during the 23-shift case -> ignored; the first result is unchanged, with a single done pulse.
- reset_n pulled low mid-shift, then released, then a new start with 25'h0800000 and exponent 127 -> all outputs 0 while reset is low, no done pulse on release; the new operation completes normally in 2 cycles.

Source files
------------

// File: rtl/fp_mantissa_normalizer.sv
// Purpose: iterative FP mantissa normalizer (one shift per clock) with zero/overflow/underflow flags.
// Latency: done pulses 2 + (number of shifts) edges after the edge that samples start (2..25).
// Backpressure: none; start is accepted only when idle and not in the done cycle, otherwise ignored.
// Ports: clk, reset_n (async active-low); start, sign_in, exponent_in, mantissa_in (carry|hidden|fraction);
//        busy, done (one-cycle pulse); sign_out, exponent_out, fraction_out; zero, overflow, underflow.
module fp_mantissa_normalizer #(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exponent_in,
  input  logic [MANT_W+1:0] mantissa_in,
  output logic              busy,
  output logic              done,
  output logic              sign_out,
  output logic [EXP_W-1:0]  exponent_out,
  output logic [MANT_W-1:0] fraction_out,
  output logic              zero,
  output logic              overflow,
  output logic              underflow
);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  localparam logic [EXP_W-1:0] EXP_INF  = '1;
  localparam logic [EXP_W-1:0] EXP_MAXF = EXP_INF - EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

  state_t              state_q, state_d;
  logic [MANT_W+1:0]   mant_q, mant_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic                sign_q, sign_d;

  logic                busy_d, done_d, sign_out_d, zero_d, overflow_d, underflow_d;
  logic [EXP_W-1:0]    exponent_out_d;
  logic [MANT_W-1:0]   fraction_out_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      mant_q       <= '0;
      exp_q        <= '0;
      sign_q       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sign_out     <= 1'b0;
      exponent_out <= '0;
      fraction_out <= '0;
      zero         <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mant_q       <= mant_d;
      exp_q        <= exp_d;
      sign_q       <= sign_d;
      busy         <= busy_d;
      done         <= done_d;
      sign_out     <= sign_out_d;
      exponent_out <= exponent_out_d;
      fraction_out <= fraction_out_d;
      zero         <= zero_d;
      overflow     <= overflow_d;
      underflow    <= underflow_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    mant_d         = mant_q;
    exp_d          = exp_q;
    sign_d         = sign_q;
    busy_d         = busy;
    done_d         = 1'b0;
    sign_out_d     = sign_out;
    exponent_out_d = exponent_out;
    fraction_out_d = fraction_out;
    zero_d         = zero;
    overflow_d     = overflow;
    underflow_d    = underflow;

    unique case (state_q)
      IDLE: begin
        // done is still high in the first IDLE cycle; a start there is dropped.
        if (start && !done) begin
          mant_d      = mantissa_in;
          exp_d       = exponent_in;
          sign_d      = sign_in;
          zero_d      = 1'b0;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = CHECK;
        end
      end

      CHECK: begin
        // Rules are ordered; only the first match acts in a given cycle.
        if (mant_q == '0) begin
          zero_d         = 1'b1;
          exponent_out_d = '0;
          fraction_out_d = '0;
          sign_out_d     = sign_q;
          state_d        = DONE;
        end else if (exp_q == EXP_INF) begin
          overflow_d     = 1'b1;
          exponent_out_d = EXP_INF;
          fraction_out_d = '0;
          sign_out_d     = sign_q;
          state_d        = DONE;
        end else if (exp_q == '0) begin
          underflow_d    = 1'b1;
          exponent_out_d = '0;
          fraction_out_d = '0;
          sign_out_d     = sign_q;
          state_d        = DONE;
        end else if (mant_q[MANT_W+1]) begin
          // Carry-out: incrementing from the largest finite exponent would hit infinity.
          if (exp_q == EXP_MAXF) begin
            overflow_d     = 1'b1;
            exponent_out_d = EXP_INF;
            fraction_out_d = '0;
            sign_out_d     = sign_q;
            state_d        = DONE;
          end else begin
            mant_d = {1'b0, mant_q[MANT_W+1:1]};
            exp_d  = exp_q + EXP_W'(1);
          end
        end else if (!mant_q[MANT_W]) begin
          // Hidden bit clear: decrementing from 1 would reach the denormal range, flush instead.
          if (exp_q == EXP_ONE) begin
            underflow_d    = 1'b1;
            exponent_out_d = '0;
            fraction_out_d = '0;
            sign_out_d     = sign_q;
            state_d        = DONE;
          end else begin
            mant_d = {mant_q[MANT_W:0], 1'b0};
            exp_d  = exp_q - EXP_W'(1);
          end
        end else begin
          exponent_out_d = exp_q;
          fraction_out_d = mant_q[MANT_W-1:0];
          sign_out_d     = sign_q;
          state_d        = DONE;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fp_mantissa_normalizer.sv
module tb_fp_mantissa_normalizer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        sign_in = 1'b0;
  logic [7:0]  exponent_in = '0;
  logic [24:0] mantissa_in = '0;
  logic        busy, done, sign_out, zero, overflow, underflow;
  logic [7:0]  exponent_out;
  logic [22:0] fraction_out;

  fp_mantissa_normalizer #(.MANT_W(23), .EXP_W(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .sign_in      (sign_in),
    .exponent_in  (exponent_in),
    .mantissa_in  (mantissa_in),
    .busy         (busy),
    .done         (done),
    .sign_out     (sign_out),
    .exponent_out (exponent_out),
    .fraction_out (fraction_out),
    .zero         (zero),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: result straight from the leading-one position of the raw mantissa.
  function automatic void model(input logic [7:0] e, input logic [24:0] m, output int lat,
                                output logic [7:0] eo, output logic [22:0] fo,
                                output logic z, output logic ov, output logic un);
    int p, d;
    logic [24:0] t;
    lat = 2; eo = '0; fo = '0; z = 1'b0; ov = 1'b0; un = 1'b0; p = -1;
    for (int i = 0; i < 25; i++) if (m[i]) p = i;
    if (p < 0) z = 1'b1;
    else if (e == 8'hFF) begin ov = 1'b1; eo = 8'hFF; end
    else if (e == 8'h00) un = 1'b1;
    else if (p == 24) begin
      if (e == 8'hFE) begin ov = 1'b1; eo = 8'hFF; end
      else begin lat = 3; eo = e + 8'd1; t = m >> 1; fo = t[22:0]; end
    end else begin
      d = 23 - p;
      if (int'(e) <= d) begin un = 1'b1; lat = 1 + int'(e); end
      else begin lat = 2 + d; eo = e - 8'(d); t = m << d; fo = t[22:0]; end
    end
  endfunction

  // Model state: cycle count, in-flight operation, expected visible outputs.
  int          cyc = 0;
  int          done_at = -1;
  bit          active = 1'b0;
  int          m_lat;
  logic        p_sign, p_zero, p_ov, p_un;
  logic [7:0]  p_exp;
  logic [22:0] p_frac;
  logic        e_sign = 1'b0, e_zero = 1'b0, e_ov = 1'b0, e_un = 1'b0;
  logic [7:0]  e_exp = '0;
  logic [22:0] e_frac = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active = 1'b0; done_at = -1;
      e_sign = 1'b0; e_zero = 1'b0; e_ov = 1'b0; e_un = 1'b0; e_exp = '0; e_frac = '0;
    end else begin
      if (start && !active) begin
        model(exponent_in, mantissa_in, m_lat, p_exp, p_frac, p_zero, p_ov, p_un);
        p_sign  = sign_in;
        done_at = cyc + 1 + m_lat;
        e_zero = 1'b0; e_ov = 1'b0; e_un = 1'b0;
        active  = 1'b1;
      end
      cyc++;
      if (active && cyc == done_at) begin
        e_sign = p_sign; e_exp = p_exp; e_frac = p_frac;
        e_zero = p_zero; e_ov = p_ov; e_un = p_un;
      end
      if (active && cyc > done_at) active = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(active && cyc < done_at));
    chk("done", 32'(done), 32'(active && cyc == done_at));
    if (!active || cyc == done_at) begin
      chk("sign_out", 32'(sign_out), 32'(e_sign));
      chk("exponent_out", 32'(exponent_out), 32'(e_exp));
      chk("fraction_out", 32'(fraction_out), 32'(e_frac));
      chk("zero", 32'(zero), 32'(e_zero));
      chk("overflow", 32'(overflow), 32'(e_ov));
      chk("underflow", 32'(underflow), 32'(e_un));
    end
  end

  task automatic issue(input logic s, input logic [7:0] e, input logic [24:0] m);
    @(negedge clk);
    sign_in = s; exponent_in = e; mantissa_in = m; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string nm, input logic s, input logic [7:0] e, input logic [24:0] m,
                        input int lat, input logic [7:0] ee, input logic [22:0] ef,
                        input logic ez, input logic eov, input logic eun);
    int n;
    issue(s, e, m);
    wait_done(n);
    chk({nm, "_latency"}, 32'(n), 32'(lat));
    chk({nm, "_sign"}, 32'(sign_out), 32'(s));
    chk({nm, "_exp"}, 32'(exponent_out), 32'(ee));
    chk({nm, "_frac"}, 32'(fraction_out), 32'(ef));
    chk({nm, "_flags"}, 32'({zero, overflow, underflow}), 32'({ez, eov, eun}));
    @(posedge clk); #1;
  endtask

  initial begin
    int n, dcount;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({busy, done, sign_out, zero, overflow, underflow}), 32'(0));
    chk("reset_exp_frac", 32'({exponent_out, fraction_out}), 32'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op("normalized", 1'b0, 8'd127, 25'h0800000, 2, 8'd127, 23'h000000, 1'b0, 1'b0, 1'b0);
    run_op("carry",      1'b0, 8'd127, 25'h1800000, 3, 8'd128, 23'h400000, 1'b0, 1'b0, 1'b0);
    run_op("shift23",    1'b1, 8'd127, 25'h0000001, 25, 8'd104, 23'h000000, 1'b0, 1'b0, 1'b0);
    run_op("zero",       1'b1, 8'd90,  25'h0000000, 2, 8'd0,   23'h000000, 1'b1, 1'b0, 1'b0);
    run_op("ovf_carry",  1'b0, 8'd254, 25'h1000000, 2, 8'd255, 23'h000000, 1'b0, 1'b1, 1'b0);
    run_op("unf_shift",  1'b1, 8'd5,   25'h0000010, 6, 8'd0,   23'h000000, 1'b0, 1'b0, 1'b1);
    run_op("inf_in",     1'b0, 8'd255, 25'h0800000, 2, 8'd255, 23'h000000, 1'b0, 1'b1, 1'b0);
    run_op("exp0_in",    1'b0, 8'd0,   25'h0C00000, 2, 8'd0,   23'h000000, 1'b0, 1'b0, 1'b1);
    run_op("carry_trunc",1'b0, 8'd100, 25'h1ABCDEF, 3, 8'd101, 23'h55E6F7, 1'b0, 1'b0, 1'b0);
    run_op("left7",      1'b1, 8'd20,  25'h0012345, 9, 8'd13,  23'h11A280, 1'b0, 1'b0, 1'b0);

    // start while busy and during the done cycle must both be ignored
    issue(1'b1, 8'd127, 25'h0000001);
    repeat (5) @(posedge clk);
    #1 sign_in = 1'b0; exponent_in = 8'd3; mantissa_in = 25'h1800000; start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    wait_done(n);
    chk("busy_start_latency", 32'(n + 7), 32'(25));
    chk("busy_start_exp", 32'(exponent_out), 32'(104));
    chk("busy_start_sign", 32'(sign_out), 32'(1));
    sign_in = 1'b0; exponent_in = 8'd127; mantissa_in = 25'h0800000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("done_cycle_start_busy", 32'(busy), 32'(0));
    repeat (3) @(posedge clk);
    #1 chk("done_cycle_start_done", 32'(done), 32'(0));

    // reset mid-shift discards the operation
    issue(1'b1, 8'd127, 25'h0000001);
    repeat (6) @(posedge clk);
    #1 reset_n = 1'b0;
    #1 chk("midreset_outputs", 32'({busy, done, sign_out, zero, overflow, underflow}), 32'(0));
    chk("midreset_exp_frac", 32'({exponent_out, fraction_out}), 32'(0));
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    dcount = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done === 1'b1) dcount++;
    end
    chk("post_reset_no_done", 32'(dcount), 32'(0));
    run_op("after_reset", 1'b0, 8'd127, 25'h0800000, 2, 8'd127, 23'h000000, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
